lsu_mem_resp: RTL and testbench

LSU_MEM_RESP -- requirements
Module: lsu_mem_resp

---
 rtl/lsu_mem_resp_if.sv | 21 ++
 rtl/lsu_mem_resp.sv | 146 ++++++++++++++
 tb/tb_lsu_mem_resp.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lsu_mem_resp_if.sv
// Request/response bundle between the LSU and the data-memory responder.
interface lsu_mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_resp.sv
// Single-outstanding LSU data-memory responder: IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module lsu_mem_resp #(
  parameter int unsigned DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_resp_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic [5:0] {
    OP_LB  = 6'b010011, OP_LH  = 6'b010100, OP_LW = 6'b010101,
    OP_LBU = 6'b010110, OP_LHU = 6'b010111,
    OP_SB  = 6'b011000, OP_SH  = 6'b011001, OP_SW = 6'b011010
  } op_e;

  state_e        state_q, state_d;
  logic [5:0]    op_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   mem [DEPTH];

  logic          accept, is_load, is_store, sgn, op_ok, misalign, err, mem_we;
  logic [1:0]    sz, lane;
  logic [3:0]    be;
  logic [31:0]   wd_rep, rd_word, rd_shift, ld_val;
  logic [AW-1:0] idx;

  assign idx    = addr_q[AW+1:2];
  assign accept = (state_q == S_IDLE) && bus.req_valid;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sgn      = 1'b0;
    op_ok    = 1'b1;
    sz       = 2'd0;
    case (op_e'(op_q))
      OP_LB:   begin is_load  = 1'b1; sgn = 1'b1; sz = 2'd0; end
      OP_LH:   begin is_load  = 1'b1; sgn = 1'b1; sz = 2'd1; end
      OP_LW:   begin is_load  = 1'b1;             sz = 2'd2; end
      OP_LBU:  begin is_load  = 1'b1;             sz = 2'd0; end
      OP_LHU:  begin is_load  = 1'b1;             sz = 2'd1; end
      OP_SB:   begin is_store = 1'b1;             sz = 2'd0; end
      OP_SH:   begin is_store = 1'b1;             sz = 2'd1; end
      OP_SW:   begin is_store = 1'b1;             sz = 2'd2; end
      default: op_ok = 1'b0;
    endcase

    misalign = ((sz == 2'd1) && addr_q[0]) || ((sz == 2'd2) && (addr_q[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    err = !op_ok || misalign;
`else
    err = !op_ok;
`endif
    // Lane always has misaligned low bits cleared; when trapping, err blocks its use.
    case (sz)
      2'd0:    lane = addr_q[1:0];
      2'd1:    lane = {addr_q[1], 1'b0};
      default: lane = 2'b00;
    endcase

    case (sz)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    case (sz)
      2'd0:    wd_rep = {4{wdata_q[7:0]}};
      2'd1:    wd_rep = {2{wdata_q[15:0]}};
      default: wd_rep = wdata_q;
    endcase

    rd_word  = mem[idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (sz)
      2'd0:    ld_val = sgn ? {{24{rd_shift[7]}}, rd_shift[7:0]}   : {24'b0, rd_shift[7:0]};
      2'd1:    ld_val = sgn ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
      default: ld_val = rd_word;
    endcase

    mem_we = (state_q == S_ACCESS) && is_store && !err;
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = err;
        resp_rdata_d = (is_load && !err) ? ld_val : '0;
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr[AW+1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // Array contents survive reset; reset only gates writes through state_q.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_rep[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_resp.sv
// Directed self-checking bench for lsu_mem_resp with hand-computed expectations.
module tb_lsu_mem_resp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lsu_mem_resp_if bus ();

  lsu_mem_resp #(.DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LB = 6'b010011, LH = 6'b010100, LW = 6'b010101,
                         LBU = 6'b010110, LHU = 6'b010111,
                         SB = 6'b011000, SH = 6'b011001, SW = 6'b011010,
                         BAD = 6'b111111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and check the full response timeline; hold keeps req_valid high throughout.
  task automatic txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input bit hold);
    chk({tag, ".ready_idle"}, {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
    chk({tag, ".access_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({tag, ".access_ready"}, {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".resp_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    chk({tag, ".resp_rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, ".resp_err"}, {31'b0, bus.resp_err}, {31'b0, exp_err});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, ".idle_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    chk({tag, ".idle_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, ".idle_err"}, {31'b0, bus.resp_err}, 32'd0);
    chk({tag, ".idle_ready"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst.valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst.rdata", bus.resp_rdata, 32'd0);
    chk("rst.err", {31'b0, bus.resp_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    txn("sw10",  SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0);
    txn("lw10",  LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    txn("lb13",  LB,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0);
    txn("lbu13", LBU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1'b0);
    txn("lh10",  LH,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 1'b0);
    txn("lhu12", LHU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 1'b0);
    txn("sb11",  SB,  32'h11, 32'h000000AA, 32'h0,        1'b0, 1'b0);
    txn("lw10b", LW,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn("lw12",  LW,  32'h12, 32'h0,        32'h0,        1'b1, 1'b0);
    txn("lh11",  LH,  32'h11, 32'h0,        32'h0,        1'b1, 1'b0);
    txn("sw11",  SW,  32'h11, 32'h01234567, 32'h0,        1'b1, 1'b0);
`else
    txn("lw12",  LW,  32'h12, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0);
    txn("lh11",  LH,  32'h11, 32'h0,        32'hFFFFAAEF, 1'b0, 1'b0);
    txn("sw11",  SW,  32'h11, 32'hDEADAAEF, 32'h0,        1'b0, 1'b0);
`endif
    txn("lw10c", LW,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0);

    txn("sw14",  SW,  32'h14, 32'h11223344, 32'h0,        1'b0, 1'b0);
    txn("sh16",  SH,  32'h16, 32'h12348001, 32'h0,        1'b0, 1'b0);
    txn("lh16",  LH,  32'h16, 32'h0,        32'hFFFF8001, 1'b0, 1'b0);
    txn("lhu14", LHU, 32'h14, 32'h0,        32'h00003344, 1'b0, 1'b0);
    txn("lw14",  LW,  32'h14, 32'h0,        32'h80013344, 1'b0, 1'b0);

    txn("swwrap", SW, 32'h00000420, 32'hCAFEF00D, 32'h0,  1'b0, 1'b0);
    txn("lwwrap", LW, 32'h00000020, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0);

    txn("bad",   BAD, 32'h10, 32'h55555555, 32'h0,        1'b1, 1'b1);
    txn("lw10d", LW,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0);

    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid.ready_access", {31'b0, bus.req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid.ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rstmid.valid", {31'b0, bus.resp_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid.hold_valid", {31'b0, bus.resp_valid}, 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.after_valid", {31'b0, bus.resp_valid}, 32'd0);
    txn("lw10e", LW,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
